// File: rtl/tt_serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM states, uio_in control bit
// positions and status byte bit positions.
package tt_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int UIO_WR_A    = 0;
  localparam int UIO_WR_B    = 1;
  localparam int UIO_START   = 2;
  localparam int UIO_SUB     = 3;
  localparam int UIO_BSEL_LO = 4;
  localparam int UIO_BSEL_HI = 5;
  localparam int UIO_RD_SEL  = 6;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;
  localparam int STAT_CARRY = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_MODE  = 4;

endpackage

// File: rtl/sa_full_adder.sv
// One-bit full adder used by the serial adder for each bit cycle.
module sa_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/tt_um_serial_adder.sv
// Bit-serial add/subtract unit: operands loaded a byte at a time, one result
// bit per cycle. Define SERIAL_ADDER_SUBTRACT_EN to honour the sub control bit.
module tt_um_serial_adder
  import tt_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int NB = WIDTH / 8;
  localparam int IW = $clog2(WIDTH);
  localparam int CW = IW + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d, res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;

  logic          wr_a, wr_b, wr_any, start, rd_sel, sub_eff, begin_op;
  logic [1:0]    bsel;
  logic [IW-1:0] bit_idx;
  logic          a_bit, b_bit, b_msb, fa_s, fa_co, last_bit;
  logic [7:0]    status, res_byte;

  assign wr_a    = uio_in[UIO_WR_A];
  assign wr_b    = uio_in[UIO_WR_B];
  assign wr_any  = wr_a | wr_b;
  assign start   = uio_in[UIO_START];
  assign rd_sel  = uio_in[UIO_RD_SEL];
  assign bsel    = uio_in[UIO_BSEL_HI:UIO_BSEL_LO];
  assign bit_idx = cnt_q[IW-1:0];
  assign a_bit   = a_q[bit_idx];
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

`ifdef SERIAL_ADDER_SUBTRACT_EN
  // Subtraction is A + ~B + 1: the +1 enters as the initial carry.
  assign sub_eff = uio_in[UIO_SUB];
  assign b_bit   = b_q[bit_idx] ^ mode_q;
  assign b_msb   = b_q[WIDTH-1] ^ mode_q;
  logic unused_in;
  assign unused_in = &{1'b0, uio_in[7]};
`else
  assign sub_eff = 1'b0;
  assign b_bit   = b_q[bit_idx];
  assign b_msb   = b_q[WIDTH-1];
  logic unused_in;
  assign unused_in = &{1'b0, uio_in[7], uio_in[UIO_SUB]};
`endif

  sa_full_adder u_fa (
    .a  (a_bit),
    .b  (b_bit),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    done_d   = done_q;
    mode_d   = mode_q;
    begin_op = 1'b0;

    case (state_q)
      IDLE: begin
        if (!wr_any && start) begin_op = 1'b1;
      end
      ADD: begin
        sum_d[bit_idx] = fa_s;
        c_d            = fa_co;
        cnt_d          = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = DONE;
          res_d   = sum_d;
          carry_d = fa_co;
          ovf_d   = (a_q[WIDTH-1] == b_msb) && (fa_s != a_q[WIDTH-1]);
          done_d  = 1'b1;
        end
      end
      DONE: begin
        if (wr_any) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else if (start) begin
          begin_op = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Operands are frozen for the whole ADD phase; out-of-range byte selects drop.
    if (state_q != ADD && wr_any) begin
      for (int i = 0; i < NB; i++) begin
        if (bsel == 2'(i)) begin
          if (wr_a) a_d[8*i +: 8] = ui_in;
          if (wr_b) b_d[8*i +: 8] = ui_in;
        end
      end
    end

    if (begin_op) begin
      state_d = ADD;
      cnt_d   = '0;
      c_d     = sub_eff;
      mode_d  = sub_eff;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      mode_q  <= 1'b0;
    end else if (ena) begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    status             = 8'h00;
    status[STAT_BUSY]  = (state_q == ADD);
    status[STAT_DONE]  = done_q;
    status[STAT_CARRY] = carry_q;
    status[STAT_OVF]   = ovf_q;
    status[STAT_MODE]  = mode_q;
    res_byte = 8'h00;
    for (int i = 0; i < NB; i++) begin
      if (bsel == 2'(i)) res_byte = res_q[8*i +: 8];
    end
  end

  assign uo_out  = rd_sel ? status : res_byte;
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: doc/tt_um_serial_adder.md
TT_UM_SERIAL_ADDER -- requirements
Module: tt_um_serial_adder

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; SHALL be a multiple of 8, legal range 8..32.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 ena  input  1  design enable; when low all state SHALL hold.
REQ-005 ui_in  input  8  data byte for operand writes.
REQ-006 uio_in  input  8  control: [0] wr_a, [1] wr_b, [2] start, [3] sub, [5:4] byte_sel, [6] rd_sel, [7] unused.
REQ-007 uo_out  output  8  rd_sel=0: result byte byte_sel; rd_sel=1: status byte.
REQ-008 uio_out  output  8  SHALL be constant 0.
REQ-009 uio_oe  output  8  SHALL be constant 0 (all uio pins are inputs).

Function
REQ-010 wr_a/wr_b high SHALL write ui_in into A/B bits [8*byte_sel +: 8]; byte_sel >= WIDTH/8 SHALL be ignored.
REQ-011 FSM states IDLE, ADD, DONE; reset state IDLE.
REQ-012 IDLE: start high with wr_a=wr_b=0 -> ADD; bit counter=0; carry=sub (with SUBTRACT_EN) else 0; sub latched into mode.
REQ-013 ADD: one bit per cycle, bit i: sum[i]=A[i]^B'[i]^c, c=majority(A[i],B'[i],c); B'=~B when mode=sub, else B.
REQ-014 ADD -> DONE after exactly WIDTH bit cycles; result, carry, overflow registered on that edge.
REQ-015 Latency: start sampled at edge t -> done=1 visible after edge t+WIDTH.
REQ-016 overflow SHALL be signed overflow: sign(A)==sign(B') and sign(result)!=sign(A).
REQ-017 In ADD, wr_a, wr_b, start SHALL be ignored; operands stable for the whole operation.
REQ-018 DONE: start -> ADD (new operation, same operands); wr_a or wr_b -> IDLE with done cleared and the write applied.
REQ-019 Simultaneous write and start in IDLE or DONE: write applied, start ignored that cycle.
REQ-020 Status byte: [0] busy (state==ADD), [1] done, [2] carry, [3] overflow, [4] mode, [7:5] 0.
REQ-021 In subtraction carry=1 means no borrow.
REQ-022 uo_out SHALL be purely combinational from registered state and uio_in[6:4]; result byte with byte_sel >= WIDTH/8 reads 0x00.
REQ-023 ena low SHALL freeze FSM, counter and registers; outputs keep reflecting held state.

Reset
REQ-024 rst_n low at a clock edge SHALL set A, B, result, counter, carry, overflow, mode, done to 0 and state to IDLE, aborting any ADD in progress.
REQ-025 After reset uo_out SHALL read 0x00 for any uio_in selection.

Configuration
REQ-026 Macro SERIAL_ADDER_SUBTRACT_EN defined: sub bit honoured per REQ-012/013.
REQ-027 Macro undefined: sub ignored, mode always 0, status bit 4 always 0, no inversion logic synthesised.

Structure
REQ-028 Package tt_serial_adder_pkg SHALL hold the state enum (IDLE/ADD/DONE), uio_in bit-index constants and status-bit index constants.
REQ-029 One sub-module, sa_full_adder (1-bit full adder), SHALL implement the per-bit sum/carry in REQ-013.
REQ-030 Bit counter SHALL be $clog2(WIDTH)+1 bits wide.

Verification (WIDTH=16)
REQ-031 A=0x00FF, B=0x0001, start -> after 16 cycles result 0x0100, status 0x02.
REQ-032 A=0xFFFF, B=0x0001, start -> busy=1 cycles 1..16, done at edge t+16, result 0x0000, status 0x06.
REQ-033 A=0x7FFF, B=0x0001 -> result 0x8000, status 0x0A (overflow, no carry).
REQ-034 With SUBTRACT_EN: A=0x0005, B=0x0007, sub=1 -> result 0xFFFE, status 0x12; without macro same stimulus -> 0x000C, status 0x02.
REQ-035 rst_n low at bit cycle 5 of an ADD -> next cycle status 0x00, result 0x0000, state IDLE.
REQ-036 start and wr_a=1 pulsed during ADD -> ignored; original result unchanged; done still at t+16.
